// File: rtl/param_flatten_loader.sv
// Streams network parameters over valid/ready into flattened weight/bias buses for the hidden and output layers.
// Each accepted element appears on its bus one cycle later; in_ready drops once all TOTAL elements are held.
module param_flatten_loader #(
  parameter int DW    = 8,
  parameter int N_IN  = 62,
  parameter int N_HID = 20,
  parameter int N_OUT = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           reload,
  input  logic [DW-1:0]                  in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           params_valid,
  output logic [1:0]                     load_seg,
  output logic [(N_IN*N_HID/2)*DW-1:0]   weight_first_h,
  output logic [(N_IN*N_HID/2)*DW-1:0]   weight_second_h,
  output logic [(N_HID/2)*DW-1:0]        bias_first_h,
  output logic [(N_HID/2)*DW-1:0]        bias_second_h,
  output logic [(N_HID*N_OUT)*DW-1:0]    weight_out,
  output logic [N_OUT*DW-1:0]            bias_out
);

  localparam int HW    = N_IN * N_HID / 2;
  localparam int HB    = N_HID / 2;
  localparam int NW2   = N_HID * N_OUT;
  localparam int TOTAL = 2 * HW + N_HID + NW2 + N_OUT;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] B1   = CW'(2 * HW);
  localparam logic [CW-1:0] B2   = CW'(2 * HW + N_HID);
  localparam logic [CW-1:0] B3   = CW'(2 * HW + N_HID + NW2);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] HW_C = CW'(HW);
  localparam logic [CW-1:0] HB_C = CW'(HB);

  typedef enum logic {LOAD, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hs, wr;
  logic [CW-1:0]   rel1, rel2, rel3, idx;
  logic [1:0]      seg;
  logic            en_wf, en_ws, en_bf, en_bs, en_wo, en_bo;

  logic [HW*DW-1:0]    weight_first_q, weight_second_q;
  logic [HB*DW-1:0]    bias_first_q, bias_second_q;
  logic [NW2*DW-1:0]   weight_out_q;
  logic [N_OUT*DW-1:0] bias_out_q;

  assign in_ready     = (state_q == LOAD);
  assign params_valid = (state_q == DONE);
  assign hs           = in_valid & in_ready;
  // reload in the same cycle as a handshake drops the element
  assign wr           = hs & ~reload;

  assign rel1 = cnt_q - B1;
  assign rel2 = cnt_q - B2;
  assign rel3 = cnt_q - B3;

  always_comb begin
    seg   = 2'd0;
    idx   = '0;
    en_wf = 1'b0;
    en_ws = 1'b0;
    en_bf = 1'b0;
    en_bs = 1'b0;
    en_wo = 1'b0;
    en_bo = 1'b0;
    if (cnt_q < B1) begin
      seg = 2'd0;
      if (cnt_q < HW_C) begin
        en_wf = wr;
        idx   = cnt_q;
      end else begin
        en_ws = wr;
        idx   = cnt_q - HW_C;
      end
    end else if (cnt_q < B2) begin
      seg = 2'd1;
      if (rel1 < HB_C) begin
        en_bf = wr;
        idx   = rel1;
      end else begin
        en_bs = wr;
        idx   = rel1 - HB_C;
      end
    end else if (cnt_q < B3) begin
      seg   = 2'd2;
      en_wo = wr;
      idx   = rel2;
    end else begin
      seg   = 2'd3;
      en_bo = wr;
      idx   = rel3;
    end
  end

  assign load_seg = (state_q == DONE) ? 2'd0 : seg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reload) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (hs) begin
      if (cnt_q == LAST) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_first_q  <= '0;
      weight_second_q <= '0;
      bias_first_q    <= '0;
      bias_second_q   <= '0;
      weight_out_q    <= '0;
      bias_out_q      <= '0;
    end else begin
      for (int i = 0; i < HW; i++) begin
        if (en_wf && idx == CW'(i)) weight_first_q[DW*i +: DW] <= in_data;
        if (en_ws && idx == CW'(i)) weight_second_q[DW*i +: DW] <= in_data;
      end
      for (int i = 0; i < HB; i++) begin
        if (en_bf && idx == CW'(i)) bias_first_q[DW*i +: DW] <= in_data;
        if (en_bs && idx == CW'(i)) bias_second_q[DW*i +: DW] <= in_data;
      end
      for (int i = 0; i < NW2; i++) begin
        if (en_wo && idx == CW'(i)) weight_out_q[DW*i +: DW] <= in_data;
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (en_bo && idx == CW'(i)) bias_out_q[DW*i +: DW] <= in_data;
      end
    end
  end

  assign weight_first_h  = weight_first_q;
  assign weight_second_h = weight_second_q;
  assign bias_first_h    = bias_first_q;
  assign bias_second_h   = bias_second_q;
  assign weight_out      = weight_out_q;
  assign bias_out        = bias_out_q;

endmodule

// File: tb/tb_param_flatten_loader.sv
// Bench for param_flatten_loader: a stream-order byte array models the loader, since the six buses
// concatenated {bo, w2, bh2, bh1, w1b, w1a} place element i at bits [8*i +: 8].
module tb_param_flatten_loader;
  localparam int DW    = 8;
  localparam int N_IN  = 62;
  localparam int N_HID = 20;
  localparam int N_OUT = 10;
  localparam int HW    = N_IN * N_HID / 2;
  localparam int HB    = N_HID / 2;
  localparam int NW2   = N_HID * N_OUT;
  localparam int TOTAL = 2 * HW + N_HID + NW2 + N_OUT;
  localparam int FW    = TOTAL * DW;

  logic              clk = 1'b0;
  logic              rst, reload, in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready, params_valid;
  logic [1:0]        load_seg;
  logic [HW*DW-1:0]  weight_first_h, weight_second_h;
  logic [HB*DW-1:0]  bias_first_h, bias_second_h;
  logic [NW2*DW-1:0] weight_out;
  logic [N_OUT*DW-1:0] bias_out;
  logic [FW-1:0]     dut_flat;

  param_flatten_loader #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .reload(reload), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .params_valid(params_valid), .load_seg(load_seg),
    .weight_first_h(weight_first_h), .weight_second_h(weight_second_h),
    .bias_first_h(bias_first_h), .bias_second_h(bias_second_h),
    .weight_out(weight_out), .bias_out(bias_out)
  );

  always #5 clk = ~clk;

  assign dut_flat = {bias_out, weight_out, bias_second_h, bias_first_h, weight_second_h, weight_first_h};

  logic [7:0] mem [TOTAL];
  int m_idx;
  bit m_done;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    int         bus;
    int         lsb;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [6];

  function automatic void model_step(bit r, bit rl, bit v, logic [7:0] d);
    if (r) begin
      for (int i = 0; i < TOTAL; i++) mem[i] = 8'h00;
      m_idx = 0;
      m_done = 0;
    end else if (rl) begin
      m_idx = 0;
      m_done = 0;
    end else if (!m_done && v) begin
      mem[m_idx] = d;
      m_idx++;
      if (m_idx == TOTAL) begin
        m_done = 1;
        m_idx = 0;
      end
    end
  endfunction

  function automatic logic [1:0] exp_seg();
    if (m_done) return 2'd0;
    if (m_idx < 2*HW) return 2'd0;
    if (m_idx < 2*HW + N_HID) return 2'd1;
    if (m_idx < 2*HW + N_HID + NW2) return 2'd2;
    return 2'd3;
  endfunction

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bus(string name);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < TOTAL; i++) begin
      if (bad < 0 && dut_flat[DW*i +: DW] !== mem[i]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: element %0d got %0h expected %0h at %0t",
               name, bad, dut_flat[DW*bad +: DW], mem[bad], $time);
    end
  endtask

  task automatic cyc(bit r, bit rl, bit v, logic [7:0] d);
    rst = r; reload = rl; in_valid = v; in_data = d;
    @(posedge clk);
    model_step(r, rl, v, d);
    #1;
    check_val("params_valid", 32'(params_valid), 32'(m_done));
    check_val("in_ready", 32'(in_ready), 32'(!m_done));
    check_val("load_seg", 32'(load_seg), 32'(exp_seg()));
    check_bus("buses");
  endtask

  // mode 0: data = index mod 256; mode 1: constant cval. Returns cycles until params_valid first seen.
  task automatic stream(int n, int mode, logic [7:0] cval, bit gaps, output int pv_at);
    int sent, c;
    sent = 0; c = 0; pv_at = -1;
    while (sent < n) begin
      c++;
      if (gaps && (c % 2 == 0)) begin
        cyc(0, 0, 0, 8'h00);
      end else begin
        cyc(0, 0, 1, (mode == 0) ? 8'(sent) : cval);
        sent++;
      end
      if (params_valid && pv_at < 0) pv_at = c;
    end
  endtask

  function automatic logic [7:0] get_byte(int bus, int lsb);
    case (bus)
      0: return weight_first_h[lsb +: 8];
      1: return weight_second_h[lsb +: 8];
      2: return bias_first_h[lsb +: 8];
      3: return bias_second_h[lsb +: 8];
      4: return weight_out[lsb +: 8];
      default: return bias_out[lsb +: 8];
    endcase
  endfunction

  task automatic check_table();
    for (int i = 0; i < 6; i++) check_val(tbl[i].name, 32'(get_byte(tbl[i].bus, tbl[i].lsb)), 32'(tbl[i].exp));
  endtask

  initial begin
    int pv_at;
    bit all_ones;
    tbl[0] = '{"wf_e0",  0, 0,  8'h00};
    tbl[1] = '{"ws_e0",  1, 0,  8'h6C};
    tbl[2] = '{"bf_e0",  2, 0,  8'hD8};
    tbl[3] = '{"bs_e0",  3, 0,  8'hE2};
    tbl[4] = '{"wo_e0",  4, 0,  8'hEC};
    tbl[5] = '{"bo_e9",  5, 72, 8'hBD};

    rst = 1; reload = 0; in_valid = 0; in_data = 0;
    m_idx = 0; m_done = 0;
    cyc(1, 0, 0, 8'h00);
    check_val("rst_pv", 32'(params_valid), 32'd0);
    check_val("rst_rdy", 32'(in_ready), 32'd1);
    check_val("rst_bus_zero", 32'(dut_flat == '0), 32'd1);

    // full stream, no gaps: params_valid on the cycle after the last handshake
    stream(TOTAL, 0, 8'h00, 0, pv_at);
    check_val("pv_nogap_cycle", 32'(pv_at), 32'(TOTAL));
    check_table();

    // DONE ignores input
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 8'h55);
      check_val("done_rdy", 32'(in_ready), 32'd0);
    end
    check_table();

    // gapped stream gives identical contents
    cyc(0, 1, 0, 8'h00);
    stream(TOTAL, 0, 8'h00, 1, pv_at);
    check_val("pv_gap_cycle", 32'((pv_at >= 2*TOTAL-2) && (pv_at <= 2*TOTAL)), 32'd1);
    check_table();

    // partial load into w2, reload, then all-ones stream
    cyc(0, 1, 0, 8'h00);
    stream(1300, 0, 8'h00, 0, pv_at);
    check_val("seg_before_reload", 32'(load_seg), 32'd2);
    cyc(0, 1, 0, 8'h00);
    check_val("seg_after_reload", 32'(load_seg), 32'd0);
    check_val("pv_after_reload", 32'(params_valid), 32'd0);
    stream(TOTAL, 1, 8'hFF, 0, pv_at);
    check_val("pv_ff_cycle", 32'(pv_at), 32'(TOTAL));
    all_ones = (dut_flat == {FW{1'b1}});
    check_val("all_ones", 32'(all_ones), 32'd1);

    // reload and handshake together: element dropped, counter restarts
    cyc(0, 1, 0, 8'h00);
    stream(5, 1, 8'hAA, 0, pv_at);
    cyc(0, 1, 1, 8'h11);
    check_val("rl_hs_seg", 32'(load_seg), 32'd0);
    check_val("rl_hs_nowrite", 32'(weight_first_h[7:0]), 32'h0AA);
    check_val("rl_hs_e5", 32'(weight_first_h[47:40]), 32'h0FF);
    cyc(0, 0, 1, 8'h22);
    check_val("rl_hs_next", 32'(weight_first_h[7:0]), 32'h022);

    // reset mid-load
    cyc(0, 1, 0, 8'h00);
    stream(700, 0, 8'h00, 0, pv_at);
    cyc(1, 0, 1, 8'h77);
    check_val("midrst_bus_zero", 32'(dut_flat == '0), 32'd1);
    check_val("midrst_rdy", 32'(in_ready), 32'd1);
    check_val("midrst_seg", 32'(load_seg), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 9000; i++) begin
      cyc(($urandom_range(0, 2999) == 0), ($urandom_range(0, 2499) == 0),
          ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
